// File: rtl/fetch_stage_unit.sv
// Instruction fetch with a single outstanding imem request, feeding the IF/ID register.
// Latency: one cycle from response to ID. stall_id holds ID, stall_if blocks issue, flush_id kills and redirects.
module fetch_stage_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_id,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_f, pc_f_nxt;
    logic [31:0] pc_out;
    logic        kill, kill_nxt;
    logic [31:0] buf_instr, buf_pc;
    logic        req;
    logic        handshake;
    logic        deliver;
    logic [31:0] deliver_instr, deliver_pc;
    logic        buf_load;
    logic        unused_redirect_bits;

    // No compressed instructions, so the low redirect bits carry no information.
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_req    = req & ~rst;
    assign imem_addr   = pc_f;
    assign handshake   = req & imem_ready;
    assign pc_plus4_id = pc_id + 32'd4;

    always_comb begin
        state_nxt     = state;
        kill_nxt      = kill;
        pc_f_nxt      = pc_f;
        req           = 1'b0;
        deliver       = 1'b0;
        deliver_instr = buf_instr;
        deliver_pc    = buf_pc;
        buf_load      = 1'b0;
        case (state)
            S_REQ: begin
                req = !stall_if && !flush_id;
                if (req && imem_ready) begin
                    pc_f_nxt  = pc_f + 32'd4;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_id) begin
                    // A response arriving with the flush is simply dropped; otherwise remember to drop it later.
                    if (imem_rvalid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    if (kill) begin
                        kill_nxt = 1'b0;
                    end else if (!stall_id) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        deliver_pc    = pc_out;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush_id) begin
                    state_nxt = S_REQ;
                end else if (!stall_id) begin
                    deliver   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        if (flush_id) begin
            pc_f_nxt = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            pc_f      <= {RESET_PC[31:2], 2'b00};
            pc_out    <= 32'd0;
            kill      <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'd0;
        end else begin
            state <= state_nxt;
            pc_f  <= pc_f_nxt;
            kill  <= kill_nxt;
            if (handshake) begin
                pc_out <= pc_f;
            end
            if (buf_load) begin
                buf_instr <= imem_rdata;
                buf_pc    <= pc_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_id <= 1'b0;
            instr_id <= NOP_INSTR;
            pc_id    <= 32'd0;
        end else if (flush_id) begin
            valid_id <= 1'b0;
            instr_id <= NOP_INSTR;
        end else if (!stall_id) begin
            // pc_id keeps the last real PC across bubbles.
            valid_id <= deliver;
            instr_id <= deliver ? deliver_instr : NOP_INSTR;
            if (deliver) begin
                pc_id <= deliver_pc;
            end
        end
    end

endmodule
